// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: store-and-forward packetizer from the FEC output stream
// to the UDP core transmit port. Collects 64-bit words into a single-packet
// buffer, closes on full buffer or in_last, then runs request/ack and streams
// the datagram out with keep/last/length.
// Optional feature macro: PKTZ_TIMEOUT_FLUSH_EN (flush a partial buffer after
// TIMEOUT_CYCLES idle cycles).
module udp_tx_packetizer #(
  parameter int unsigned PKT_WORDS      = 128,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic        clk_15_625,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  input  logic        in_last,
  input  logic        udp_tx_ready,
  output logic        app_tx_request,
  input  logic        app_tx_ack,
  input  logic        dst_ip_unreachable,
  output logic        app_tx_data_valid,
  output logic [63:0] app_tx_data,
  output logic [7:0]  app_tx_data_keep,
  output logic        app_tx_data_last,
  output logic [15:0] app_tx_data_length,
  output logic [15:0] tx_pkt_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned CW = $clog2(PKT_WORDS + 1);
  localparam int unsigned AW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = 8;
  localparam int unsigned LW = 16;
`ifdef PKTZ_TIMEOUT_FLUSH_EN
  localparam int unsigned IW = 24;
`endif

  typedef enum logic [1:0] {
    FILL,
    WAIT_READY,
    WAIT_ACK,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   nwords_q, nwords_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [KW-1:0]   lkeep_q, lkeep_d;
  logic [LW-1:0]   len_q, len_d;
  logic            in_ready_q, in_ready_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [KW-1:0]   keep_q, keep_d;
  logic [DW-1:0]   data_q, data_d;
  logic [LW-1:0]   txcnt_q, txcnt_d;
  logic [LW-1:0]   drop_q, drop_d;
`ifdef PKTZ_TIMEOUT_FLUSH_EN
  logic [IW-1:0]   idle_q, idle_d;
`else
  logic            unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT_CYCLES;
`endif

  logic [DW-1:0]   mem_q [PKT_WORDS];
  logic            wr_en_c;
  logic [AW-1:0]   rd_addr_c;
  logic [DW-1:0]   rd_word_c;
  logic            accept_c;
  logic [CW-1:0]   wcnt_inc_c;
  logic [CW-1:0]   rcnt_inc_c;
  logic [KW-1:0]   lk_c;

  assign accept_c   = in_valid && in_ready_q;
  assign wcnt_inc_c = wcnt_q + CW'(1);
  assign rcnt_inc_c = rcnt_q + CW'(1);
  assign lk_c       = in_last ? in_keep : 8'hff;

  // Read address prefetch: word 0 is presented while waiting for the ack.
  assign rd_addr_c = (state_q == SEND) ? rcnt_q[AW-1:0] : '0;
  assign rd_word_c = mem_q[rd_addr_c];

  // Packet buffer write port.
  always_ff @(posedge clk_15_625) begin
    if (wr_en_c) begin
      mem_q[wcnt_q[AW-1:0]] <= in_data;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    nwords_d = nwords_q;
    rcnt_d   = rcnt_q;
    lkeep_d  = lkeep_q;
    len_d    = len_q;
    req_d    = 1'b0;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    keep_d   = 8'hff;
    data_d   = data_q;
    txcnt_d  = txcnt_q;
    drop_d   = drop_q;
    wr_en_c  = 1'b0;
`ifdef PKTZ_TIMEOUT_FLUSH_EN
    idle_d   = '0;
`endif

    case (state_q)
      FILL: begin
        if (accept_c) begin
          wr_en_c = 1'b1;
          wcnt_d  = wcnt_inc_c;
          if ((wcnt_inc_c == CW'(PKT_WORDS)) || in_last) begin
            state_d  = WAIT_READY;
            nwords_d = wcnt_inc_c;
            lkeep_d  = lk_c;
            len_d    = (LW'(wcnt_q) << 3) + LW'($countones(lk_c));
          end
        end
`ifdef PKTZ_TIMEOUT_FLUSH_EN
        else if (wcnt_q != '0) begin
          idle_d = idle_q + IW'(1);
          if (idle_d == TIMEOUT_CYCLES) begin
            state_d  = WAIT_READY;
            nwords_d = wcnt_q;
            lkeep_d  = 8'hff;
            len_d    = LW'(wcnt_q) << 3;
            idle_d   = '0;
          end
        end
`endif
      end
      WAIT_READY: begin
        if (udp_tx_ready) begin
          state_d = WAIT_ACK;
          req_d   = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (app_tx_ack) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = rd_word_c;
          rcnt_d  = CW'(1);
          last_d  = (nwords_q == CW'(1));
          keep_d  = last_d ? lkeep_q : 8'hff;
        end else if (dst_ip_unreachable) begin
          state_d = FILL;
          wcnt_d  = '0;
          if (drop_q != 16'hffff) begin
            drop_d = drop_q + LW'(1);
          end
        end else begin
          req_d = 1'b1;
        end
      end
      SEND: begin
        if (rcnt_q != nwords_q) begin
          valid_d = 1'b1;
          data_d  = rd_word_c;
          rcnt_d  = rcnt_inc_c;
          last_d  = (rcnt_inc_c == nwords_q);
          keep_d  = last_d ? lkeep_q : 8'hff;
        end else begin
          state_d = FILL;
          wcnt_d  = '0;
          txcnt_d = txcnt_q + LW'(1);
        end
      end
      default: begin
        state_d = FILL;
        wcnt_d  = '0;
      end
    endcase

    in_ready_d = (state_d == FILL) && (wcnt_d < CW'(PKT_WORDS));
  end

  // State and output registers.
  always_ff @(posedge clk_15_625 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      nwords_q   <= '0;
      rcnt_q     <= '0;
      lkeep_q    <= 8'hff;
      len_q      <= '0;
      in_ready_q <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      keep_q     <= 8'hff;
      data_q     <= '0;
      txcnt_q    <= '0;
      drop_q     <= '0;
`ifdef PKTZ_TIMEOUT_FLUSH_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      nwords_q   <= nwords_d;
      rcnt_q     <= rcnt_d;
      lkeep_q    <= lkeep_d;
      len_q      <= len_d;
      in_ready_q <= in_ready_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      keep_q     <= keep_d;
      data_q     <= data_d;
      txcnt_q    <= txcnt_d;
      drop_q     <= drop_d;
`ifdef PKTZ_TIMEOUT_FLUSH_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign in_ready           = in_ready_q;
  assign app_tx_request     = req_q;
  assign app_tx_data_valid  = valid_q;
  assign app_tx_data        = data_q;
  assign app_tx_data_keep   = keep_q;
  assign app_tx_data_last   = last_q;
  assign app_tx_data_length = len_q;
  assign tx_pkt_cnt         = txcnt_q;
  assign drop_cnt           = drop_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Self-checking bench for udp_tx_packetizer: vector table of datagrams plus
// directed sequences for backpressure, unreachable, idle flush and reset.
module tb_udp_tx_packetizer;

`ifdef PKTZ_TIMEOUT_FLUSH_EN
  localparam logic [23:0] TB_TMO = 24'd100;
`else
  localparam logic [23:0] TB_TMO = 24'd1_000_000;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last;
  logic        udp_tx_ready;
  logic        app_tx_request;
  logic        app_tx_ack;
  logic        dst_ip_unreachable;
  logic        app_tx_data_valid;
  logic [63:0] app_tx_data;
  logic [7:0]  app_tx_data_keep;
  logic        app_tx_data_last;
  logic [15:0] app_tx_data_length;
  logic [15:0] tx_pkt_cnt;
  logic [15:0] drop_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_tx = 0;

  udp_tx_packetizer #(
    .PKT_WORDS      (128),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk_15_625         (clk),
    .reset_n            (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .in_keep            (in_keep),
    .in_last            (in_last),
    .udp_tx_ready       (udp_tx_ready),
    .app_tx_request     (app_tx_request),
    .app_tx_ack         (app_tx_ack),
    .dst_ip_unreachable (dst_ip_unreachable),
    .app_tx_data_valid  (app_tx_data_valid),
    .app_tx_data        (app_tx_data),
    .app_tx_data_keep   (app_tx_data_keep),
    .app_tx_data_last   (app_tx_data_last),
    .app_tx_data_length (app_tx_data_length),
    .tx_pkt_cnt         (tx_pkt_cnt),
    .drop_cnt           (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          use_last;
    logic [7:0]  keep;
    int          ack_dly;
    logic [15:0] exp_len;
    logic [7:0]  exp_keep;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  function automatic logic [63:0] mk(input int pid, input int i);
    return {8'(pid), 8'hA5, 16'(i), ((32'(i) * 32'h9E3779B1) ^ 32'(pid))};
  endfunction

  function automatic logic [63:0] byte_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  // Push n words of packet pid, honouring in_ready; non-last words carry junk keep.
  task automatic push_pkt(input int pid, input int n, input bit use_last, input logic [7:0] keep);
    for (int i = 0; i < n; i++) begin
      int w;
      in_valid = 1'b1;
      in_data  = mk(pid, i);
      in_last  = use_last && (i == n - 1);
      in_keep  = (i == n - 1) ? keep : 8'h3c;
      w = 0;
      while (!in_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300) bound_expired("push_in_ready");
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 8'hff;
  endtask

  task automatic wait_req(output int cycles);
    cycles = 0;
    while (!app_tx_request && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 2000) bound_expired("wait_request");
  endtask

  // Hold off the ack, grant it, then check every beat of the datagram.
  task automatic ack_and_collect(input int pid, input int n, input int dly, input logic [7:0] exp_keep);
    for (int d = 0; d < dly; d++) begin
      chk("req_hold", 64'(app_tx_request), 64'd1);
      @(negedge clk);
    end
    app_tx_ack = 1'b1;
    @(negedge clk);
    app_tx_ack = 1'b0;
    chk("req_drop", 64'(app_tx_request), 64'd0);
    for (int i = 0; i < n; i++) begin
      logic [7:0] k;
      k = (i == n - 1) ? exp_keep : 8'hff;
      chk("beat_valid", 64'(app_tx_data_valid), 64'd1);
      chk("beat_last", 64'(app_tx_data_last), 64'(i == n - 1));
      chk("beat_keep", 64'(app_tx_data_keep), 64'(k));
      chk("beat_data", app_tx_data & byte_mask(k), mk(pid, i) & byte_mask(k));
      @(negedge clk);
    end
    chk("valid_end", 64'(app_tx_data_valid), 64'd0);
  endtask

  initial begin
    int c;
    bit bad;

    vecs[0] = '{128, 1'b0, 8'h00, 2, 16'd1024, 8'hff};
    vecs[1] = '{3,   1'b1, 8'h07, 0, 16'd19,   8'h07};
    vecs[2] = '{1,   1'b1, 8'h01, 1, 16'd1,    8'h01};
    vecs[3] = '{5,   1'b1, 8'hff, 3, 16'd40,   8'hff};
    vecs[4] = '{128, 1'b1, 8'h0f, 0, 16'd1020, 8'h0f};
    vecs[5] = '{2,   1'b1, 8'h3f, 1, 16'd14,   8'h3f};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_keep = 8'hff;
    in_last = 1'b0;
    udp_tx_ready = 1'b1;
    app_tx_ack = 1'b0;
    dst_ip_unreachable = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_request", 64'(app_tx_request), 64'd0);
    chk("rst_valid", 64'(app_tx_data_valid), 64'd0);
    chk("rst_last", 64'(app_tx_data_last), 64'd0);
    chk("rst_keep", 64'(app_tx_data_keep), 64'hff);
    chk("rst_data", app_tx_data, 64'd0);
    chk("rst_length", 64'(app_tx_data_length), 64'd0);
    chk("rst_tx_cnt", 64'(tx_pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Table-driven datagrams
    for (int k = 0; k < 6; k++) begin
      push_pkt(k, vecs[k].n, vecs[k].use_last, vecs[k].keep);
      chk("in_ready_closed", 64'(in_ready), 64'd0);
      chk("req_at_close", 64'(app_tx_request), 64'd0);
      chk("length_at_close", 64'(app_tx_data_length), 64'(vecs[k].exp_len));
      wait_req(c);
      chk("req_latency", 64'(c), 64'd1);
      ack_and_collect(k, vecs[k].n, vecs[k].ack_dly, vecs[k].exp_keep);
      exp_tx++;
      chk("tx_pkt_cnt", 64'(tx_pkt_cnt), 64'(exp_tx));
      chk("length_hold", 64'(app_tx_data_length), 64'(vecs[k].exp_len));
    end

    // udp_tx_ready held low after close
    udp_tx_ready = 1'b0;
    push_pkt(10, 4, 1'b1, 8'hff);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (app_tx_request || in_ready) bad = 1'b1;
      @(negedge clk);
    end
    chk("not_ready_hold", 64'(bad), 64'd0);
    udp_tx_ready = 1'b1;
    @(negedge clk);
    chk("req_after_ready", 64'(app_tx_request), 64'd1);
    ack_and_collect(10, 4, 0, 8'hff);
    exp_tx++;
    chk("tx_cnt_ready_seq", 64'(tx_pkt_cnt), 64'(exp_tx));

    // Unreachable destination drops the datagram
    push_pkt(20, 3, 1'b1, 8'h07);
    wait_req(c);
    dst_ip_unreachable = 1'b1;
    @(negedge clk);
    dst_ip_unreachable = 1'b0;
    chk("unreach_req", 64'(app_tx_request), 64'd0);
    chk("unreach_in_ready", 64'(in_ready), 64'd1);
    chk("unreach_drop_cnt", 64'(drop_cnt), 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (app_tx_data_valid) bad = 1'b1;
      @(negedge clk);
    end
    chk("unreach_no_beats", 64'(bad), 64'd0);
    chk("unreach_tx_cnt", 64'(tx_pkt_cnt), 64'(exp_tx));

    // Ack and unreachable together: ack wins
    push_pkt(21, 2, 1'b1, 8'hff);
    wait_req(c);
    dst_ip_unreachable = 1'b1;
    ack_and_collect(21, 2, 0, 8'hff);
    dst_ip_unreachable = 1'b0;
    exp_tx++;
    chk("both_tx_cnt", 64'(tx_pkt_cnt), 64'(exp_tx));
    chk("both_drop_cnt", 64'(drop_cnt), 64'd1);

    // Partial buffer left idle
    push_pkt(25, 5, 1'b0, 8'h00);
    chk("partial_in_ready", 64'(in_ready), 64'd1);
`ifdef PKTZ_TIMEOUT_FLUSH_EN
    wait_req(c);
    chk("flush_delay", 64'((c >= 100) && (c <= 103)), 64'd1);
    chk("flush_length", 64'(app_tx_data_length), 64'd40);
    ack_and_collect(25, 5, 0, 8'hff);
    exp_tx++;
    chk("flush_tx_cnt", 64'(tx_pkt_cnt), 64'(exp_tx));
`else
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (app_tx_request) bad = 1'b1;
      @(negedge clk);
    end
    chk("no_flush", 64'(bad), 64'd0);
`endif

    // Reset in FILL discards the partial buffer
    rst_n = 1'b0;
    #1;
    chk("rst_fill_in_ready", 64'(in_ready), 64'd0);
    chk("rst_fill_tx_cnt", 64'(tx_pkt_cnt), 64'd0);
    chk("rst_fill_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_tx = 0;

    // Reset during beat 10 of a 128-word send
    push_pkt(30, 128, 1'b0, 8'hff);
    wait_req(c);
    app_tx_ack = 1'b1;
    @(negedge clk);
    app_tx_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("pre_rst_data", app_tx_data, mk(30, i));
      if (i < 9) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_send_valid", 64'(app_tx_data_valid), 64'd0);
    chk("rst_send_data", app_tx_data, 64'd0);
    chk("rst_send_keep", 64'(app_tx_data_keep), 64'hff);
    chk("rst_send_length", 64'(app_tx_data_length), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (app_tx_data_valid || app_tx_request) bad = 1'b1;
    end
    chk("no_stale_beats", 64'(bad), 64'd0);
    chk("post_rst_tx_cnt", 64'(tx_pkt_cnt), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Normal traffic resumes with fresh data
    push_pkt(31, 2, 1'b1, 8'h0f);
    chk("resume_length", 64'(app_tx_data_length), 64'd12);
    wait_req(c);
    ack_and_collect(31, 2, 1, 8'h0f);
    exp_tx++;
    chk("resume_tx_cnt", 64'(tx_pkt_cnt), 64'(exp_tx));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
